// File: rtl/lgn_pixel_loader.sv
// Pixel stream binarizer/packer feeding the logic-gate-network classifier input port.
// Optional macro LGN_LOADER_INVERT_EN selects dark-foreground binarization (pix < threshold).
module lgn_pixel_loader #(
  parameter int unsigned PIXELS        = 784,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] threshold,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  output logic [7:0] out_byte,
  output logic       out_we,
  output logic       busy,
  output logic       result_valid,
  output logic       frame_done,
  output logic       err_sync
);

  localparam int unsigned CW = $clog2(PIXELS);
  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_PIX   = CW'(PIXELS - 1);
  localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DONE} state_t;

  state_t        r_state;
  logic [7:0]    r_thr;
  logic [CW-1:0] r_pix_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [7:0]    r_pack;
  logic [7:0]    r_out_byte;
  logic          r_out_we;
  logic          r_busy;
  logic          r_result_valid;
  logic          r_frame_done;
  logic          r_err_sync;

  logic w_accept;
  logic w_bit_sof;
  logic w_bit;

  function automatic logic binarize(input logic [7:0] d, input logic [7:0] t);
`ifdef LGN_LOADER_INVERT_EN
    return d < t;
`else
    return d >= t;
`endif
  endfunction

  assign pix_ready    = ~rst & (r_state != SETTLE);
  assign w_accept     = pix_valid & pix_ready;
  // The SOF beat is judged against the incoming threshold, since thr_q latches on that same edge.
  assign w_bit_sof    = binarize(pix_data, threshold);
  assign w_bit        = binarize(pix_data, r_thr);

  assign out_byte     = r_out_byte;
  assign out_we       = r_out_we;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign frame_done   = r_frame_done;
  assign err_sync     = r_err_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_thr          <= '0;
      r_pix_cnt      <= '0;
      r_settle_cnt   <= '0;
      r_pack         <= '0;
      r_out_byte     <= '0;
      r_out_we       <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_frame_done   <= 1'b0;
      r_err_sync     <= 1'b0;
    end else begin
      r_out_we     <= 1'b0;
      r_frame_done <= 1'b0;
      // SOF is handled identically from IDLE, LOAD and DONE; only a mid-frame SOF is an error.
      if (w_accept && pix_sof) begin
        r_thr          <= threshold;
        r_pack         <= {7'b0, w_bit_sof};
        r_pix_cnt      <= CW'(1);
        r_state        <= LOAD;
        r_busy         <= 1'b1;
        r_result_valid <= 1'b0;
        if (r_state == LOAD) r_err_sync <= 1'b1;
      end else begin
        case (r_state)
          IDLE, DONE: begin
            if (w_accept) r_err_sync <= 1'b1;
          end
          LOAD: begin
            if (w_accept) begin
              r_pack <= {r_pack[6:0], w_bit};
              if (r_pix_cnt[2:0] == 3'd7) begin
                r_out_byte <= {r_pack[6:0], w_bit};
                r_out_we   <= 1'b1;
              end
              if (r_pix_cnt == LAST_PIX) begin
                r_pix_cnt <= '0;
                r_state   <= SETTLE;
              end else begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
              end
            end
          end
          SETTLE: begin
            if (r_settle_cnt == SETTLE_END) begin
              r_settle_cnt   <= '0;
              r_state        <= DONE;
              r_busy         <= 1'b0;
              r_result_valid <= 1'b1;
              r_frame_done   <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
